// File: rtl/wb_queue_if.sv
// Producer-side push channel of the write-back queue.
// A transfer happens on a rising clk edge where wb_valid and wb_ready are both 1.
// The producer holds wb_reg/wb_data stable while wb_valid=1 and wb_ready=0.
// wb_ready does not depend on wb_valid.
interface wb_queue_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;

  modport master (output wb_valid, output wb_reg, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_reg, input wb_data, output wb_ready);
endinterface

// File: rtl/wb_queue.sv
// In-order write-back buffer feeding the register file's one-hot write port.
// It also offers a combinational forwarding lookup over pending results.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  wb_queue_if.slave              bus,
  input  logic                   rf_hold,
  output logic [(1<<AW)-1:0]     write,
  output logic [DW-1:0]          D,
  input  logic [AW-1:0]          fwd_reg,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = 1 << AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] ent_reg   [DEPTH];
  logic [DW-1:0] ent_data  [DEPTH];
  logic          ent_valid [DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic          push, pop;

  assign bus.wb_ready = (count < FULL);
  assign push  = bus.wb_valid & bus.wb_ready;
  assign pop   = (count != '0) & ~rf_hold;
  assign empty = (count == '0) && (write == '0);

  // Push and pop never target the same slot: push needs count<DEPTH and pop
  // needs count>0, so head==tail cannot occur when both fire.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      write <= '0;
      D     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]   <= '0;
        ent_data[i]  <= '0;
        ent_valid[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        ent_reg[tail]   <= bus.wb_reg;
        ent_data[tail]  <= bus.wb_data;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (pop) begin
        write           <= NW'(1) << ent_reg[head];
        D               <= ent_data[head];
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end else begin
        write <= '0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage has lowest priority; scanning from head toward tail lets
  // each younger match overwrite the older one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    if (write[fwd_reg]) begin
      fwd_hit  = 1'b1;
      fwd_data = D;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (ent_valid[idx] && (ent_reg[idx] == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, single commit, hold/drain, forwarding,
// streaming with pointer wrap, async reset mid-drain and full-queue rejection.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          rf_hold = 1'b0;
  logic [15:0]   write;
  logic [31:0]   D;
  logic [3:0]    fwd_reg = '0;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [2:0]    count;
  logic          empty;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_q[$];

  wb_queue_if #(.DW(DW), .AW(AW)) bus ();

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .clr(clr), .bus(bus.slave), .rf_hold(rf_hold),
    .write(write), .D(D), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled at +1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_reg   = r;
    bus.wb_data  = d;
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 32'd0);
    #12;
    checks++; if (write !== 16'h0) begin errors++; $display("FAIL reset_write got=%h exp=0000", write); end
    checks++; if (D !== 32'h0) begin errors++; $display("FAIL reset_D got=%h exp=0", D); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    clr = 1'b1;
    #1;
    checks++; if (bus.wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.wb_ready); end
  endtask

  task automatic test_single();
    @(negedge clk);
    drive(1'b1, 4'd5, 32'hDEADBEEF);
    cyc();
    drive(1'b0, 4'd0, 32'd0);
    checks++; if (write !== 16'h0) begin errors++; $display("FAIL single_nobypass got=%h exp=0000", write); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    cyc();
    checks++; if (write !== 16'h0020) begin errors++; $display("FAIL single_write got=%h exp=0020", write); end
    checks++; if (D !== 32'hDEADBEEF) begin errors++; $display("FAIL single_D got=%h exp=deadbeef", D); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", empty); end
    cyc();
    checks++; if (write !== 16'h0) begin errors++; $display("FAIL single_oneshot got=%h exp=0000", write); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
    checks++; if (D !== 32'hDEADBEEF) begin errors++; $display("FAIL single_Dhold got=%h exp=deadbeef", D); end
  endtask

  task automatic test_hold_drain();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 4'(i), 32'h11 * i);
      cyc();
    end
    drive(1'b0, 4'd0, 32'd0);
    checks++; if (bus.wb_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b exp=0", bus.wb_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_count got=%0d exp=4", count); end
    repeat (3) cyc();
    checks++; if (write !== 16'h0 || count !== 3'd4) begin errors++; $display("FAIL hold_keep write=%h count=%0d exp 0000/4", write, count); end
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (write !== (16'h1 << i)) begin errors++; $display("FAIL drain_write%0d got=%h exp=%h", i, write, 16'h1 << i); end
      checks++; if (D !== 32'h11 * i) begin errors++; $display("FAIL drain_D%0d got=%h exp=%h", i, D, 32'h11 * i); end
    end
    cyc();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_forward();
    rf_hold = 1'b1;
    fwd_reg = 4'd7;
    drive(1'b1, 4'd7, 32'hA);
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_prepush got=%b exp=0", fwd_hit); end
    cyc();
    drive(1'b1, 4'd7, 32'hB);
    cyc();
    drive(1'b0, 4'd0, 32'd0);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin errors++; $display("FAIL fwd_young hit=%b data=%h exp 1/b", fwd_hit, fwd_data); end
    fwd_reg = 4'd8;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss hit=%b data=%h exp 0/0", fwd_hit, fwd_data); end
    fwd_reg = 4'd7;
    rf_hold = 1'b0;
    cyc();
    checks++; if (write !== 16'h0080 || D !== 32'hA) begin errors++; $display("FAIL fwd_pop1 write=%h D=%h exp 0080/a", write, D); end
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin errors++; $display("FAIL fwd_queue_over_stage hit=%b data=%h exp 1/b", fwd_hit, fwd_data); end
    cyc();
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin errors++; $display("FAIL fwd_stage hit=%b data=%h exp 1/b", fwd_hit, fwd_data); end
    cyc();
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin errors++; $display("FAIL fwd_drained hit=%b data=%h exp 0/0", fwd_hit, fwd_data); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    logic [3:0]  r;
    for (int k = 0; k <= 21; k++) begin
      r = 4'((k * 3) % 16);
      if (k <= 20) begin
        drive(1'b1, r, 32'h100 + k);
        exp_q.push_back({r, 28'(32'h100 + k)});
      end else begin
        drive(1'b0, 4'd0, 32'd0);
      end
      cyc();
      if (k >= 1) begin
        e = exp_q.pop_front();
        checks++; if (D !== {4'h0, e[27:0]} || write !== (16'h1 << e[31:28])) begin
          errors++; $display("FAIL stream_out%0d write=%h D=%h exp %h/%h", k, write, D, 16'h1 << e[31:28], {4'h0, e[27:0]});
        end
        checks++; if (count !== ((k <= 20) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL stream_count%0d got=%0d", k, count); end
      end
    end
    cyc();
    checks++; if (empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL stream_end empty=%b left=%0d exp 1/0", empty, exp_q.size()); end
  endtask

  task automatic test_async_reset();
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(9 + i), 32'h900 + i);
      cyc();
    end
    drive(1'b0, 4'd0, 32'd0);
    rf_hold = 1'b0;
    cyc();
    checks++; if (count !== 3'd3 || write !== 16'h0200) begin errors++; $display("FAIL arst_pre count=%0d write=%h exp 3/0200", count, write); end
    #2;
    clr = 1'b0;
    #1;
    checks++; if (write !== 16'h0 || count !== 3'd0 || empty !== 1'b1 || D !== 32'h0) begin
      errors++; $display("FAIL arst_now write=%h count=%0d empty=%b D=%h exp 0000/0/1/0", write, count, empty, D);
    end
    cyc();
    #2;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (write !== 16'h0 || empty !== 1'b1) begin errors++; $display("FAIL arst_after%0d write=%h empty=%b", i, write, empty); end
    end
  endtask

  task automatic test_full_reject();
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 32'h50 + i);
      cyc();
    end
    rf_hold = 1'b0;
    drive(1'b1, 4'd15, 32'h99);
    cyc();
    drive(1'b0, 4'd0, 32'd0);
    checks++; if (count !== 3'd3 || write !== 16'h0001) begin errors++; $display("FAIL full_reject count=%0d write=%h exp 3/0001", count, write); end
    for (int i = 1; i < 4; i++) begin
      cyc();
      checks++; if (D !== 32'h50 + i || write !== (16'h1 << i)) begin errors++; $display("FAIL full_drain%0d write=%h D=%h", i, write, D); end
    end
    cyc();
    checks++; if (write !== 16'h0 || empty !== 1'b1) begin errors++; $display("FAIL full_absent write=%h empty=%b exp 0000/1", write, empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_drain();
    test_forward();
    test_stream();
    test_async_reset();
    test_full_reject();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
